// File: rtl/ej32_prefetch.sv
// ej32_prefetch: sequential instruction byte prefetch FIFO between the 8-bit bus and the decoder
// Optional same-cycle bypass of a return into an empty FIFO: define EJ32_PF_BYPASS_EN
module ej32_prefetch #(
    parameter int ASZ = 17,
    parameter int DEPTH = 4,
    parameter logic [ASZ-1:0] COLD = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [ASZ-1:0]             flush_a,
    input  logic                       mem_gnt,
    input  logic [7:0]                 mem_d,
    output logic                       mem_req,
    output logic [ASZ-1:0]             mem_a,
    output logic [7:0]                 op_o,
    output logic [ASZ-1:0]             op_p,
    output logic                       op_vld,
    input  logic                       op_rdy,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [7:0]     fifo_q [DEPTH];
    logic [7:0]     fifo_d [DEPTH];
    logic [PW-1:0]  rp_q, rp_d, wp_q, wp_d;
    logic [CW-1:0]  cnt_q, cnt_d, rem;
    logic [ASZ-1:0] fa_q, fa_d, hp_q, hp_d;
    logic           infl_q, infl_d, kill_q, kill_d;
    logic [7:0]     op_o_q, op_o_d;
    logic           ret, byp, pop, fifo_pop, fifo_wr;
    // A slot is reserved for every in-flight byte so a return can never overflow
    assign mem_req = en & mem_gnt & ~flush & ((cnt_q + CW'(infl_q)) < CW'(DEPTH));
    assign mem_a   = fa_q;
    assign ret     = infl_q & ~kill_q;
`ifdef EJ32_PF_BYPASS_EN
    assign byp     = ret & (cnt_q == '0);
`else
    assign byp     = 1'b0;
`endif
    assign op_vld   = (cnt_q != '0) | byp;
    assign op_o     = byp ? mem_d : op_o_q;
    assign op_p     = hp_q;
    assign cnt      = cnt_q;
    assign pop      = op_vld & op_rdy;
    assign fifo_pop = pop & ~byp;
    assign fifo_wr  = ret & ~(byp & op_rdy);
    assign rem      = cnt_q - CW'(fifo_pop);
    // Next FIFO/pointer state and the registered head byte; flush overrides everything
    always_comb begin
        fifo_d = fifo_q;
        if (fifo_wr) fifo_d[wp_q] = mem_d;
        wp_d   = wp_q + PW'(fifo_wr);
        rp_d   = rp_q + PW'(fifo_pop);
        cnt_d  = rem + CW'(fifo_wr);
        fa_d   = mem_req ? fa_q + ASZ'(1) : fa_q;
        hp_d   = pop ? hp_q + ASZ'(1) : hp_q;
        infl_d = mem_req;
        kill_d = flush;
        op_o_d = (cnt_d == '0) ? 8'h00 : (rem == '0) ? mem_d : fifo_q[rp_d];
        if (flush) begin
            rp_d   = '0;
            wp_d   = '0;
            cnt_d  = '0;
            fa_d   = flush_a;
            hp_d   = flush_a;
            op_o_d = 8'h00;
        end
    end
    // Control state with synchronous reset; a pending return is dropped by clearing inflight
    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            fa_q   <= COLD;
            hp_q   <= COLD;
            infl_q <= 1'b0;
            kill_q <= 1'b0;
            op_o_q <= 8'h00;
        end else begin
            rp_q   <= rp_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            fa_q   <= fa_d;
            hp_q   <= hp_d;
            infl_q <= infl_d;
            kill_q <= kill_d;
            op_o_q <= op_o_d;
        end
    end
    // Byte storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_ej32_prefetch.sv
// tb_ej32_prefetch: randomized scoreboard bench for ej32_prefetch against a queue-based byte-stream model
module tb_ej32_prefetch;
    localparam int ASZ = 17;
    localparam int DEPTH = 4;
    localparam logic [ASZ-1:0] COLD = '0;
`ifdef EJ32_PF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic           clk, rst, en, flush, mem_gnt, op_rdy;
    logic [ASZ-1:0] flush_a, mem_a, op_p;
    logic [7:0]     mem_d, op_o;
    logic           mem_req, op_vld;
    logic [2:0]     cnt;

    ej32_prefetch #(.ASZ(ASZ), .DEPTH(DEPTH), .COLD(COLD)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .flush_a(flush_a),
        .mem_gnt(mem_gnt), .mem_d(mem_d), .mem_req(mem_req), .mem_a(mem_a),
        .op_o(op_o), .op_p(op_p), .op_vld(op_vld), .op_rdy(op_rdy), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [ASZ-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]};
    endfunction

    // Bus memory: answers every request one cycle later
    logic           ret_v;
    logic [ASZ-1:0] ret_a;
    always @(posedge clk) begin
        ret_v <= mem_req;
        ret_a <= mem_a;
    end
    assign mem_d = ret_v ? memf(ret_a) : 8'hEE;

    int passes = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of addresses of bytes held for the decoder
    logic [ASZ-1:0] mq[$];
    logic [ASZ-1:0] m_hp, m_fa, m_ra;
    bit             m_infl, armed, just_rst;
    bit             er, ev, by;
    int             sz;

    always @(negedge clk) begin
        if (armed) begin
            sz = mq.size();
            er = en & mem_gnt & ~flush & ((sz + int'(m_infl)) < DEPTH);
            by = BYP && sz == 0 && m_infl;
            ev = sz > 0 || by;
            chk("mem_req", 32'(mem_req), 32'(er));
            if (er) chk("mem_a", 32'(mem_a), 32'(m_fa));
            chk("op_vld", 32'(op_vld), 32'(ev));
            chk("cnt", 32'(cnt), 32'(sz));
            chk("op_p", 32'(op_p), 32'(m_hp));
            if (ev) chk("op_o", 32'(op_o), 32'(memf(sz > 0 ? mq[0] : m_ra)));
            if (just_rst) chk("op_o_rst", 32'(op_o), 32'h0);
            just_rst = rst;
            if (rst) begin
                mq.delete();
                m_hp = COLD;
                m_fa = COLD;
                m_infl = 1'b0;
            end else if (flush) begin
                mq.delete();
                m_hp = flush_a;
                m_fa = flush_a;
                m_infl = 1'b0;
            end else begin
                if (by && op_rdy) m_hp = m_hp + 1'b1;
                else begin
                    if (m_infl) mq.push_back(m_ra);
                    if (ev && op_rdy) begin
                        void'(mq.pop_front());
                        m_hp = m_hp + 1'b1;
                    end
                end
                if (er) begin
                    m_ra = m_fa;
                    m_fa = m_fa + 1'b1;
                end
                m_infl = er;
            end
        end
    end

    task automatic cyc(input bit r, input bit f, input logic [ASZ-1:0] fa,
                       input bit e, input bit g, input bit rd);
        @(posedge clk);
        #1;
        rst = r; flush = f; flush_a = fa; en = e; mem_gnt = g; op_rdy = rd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_a = '0; en = 1'b0; mem_gnt = 1'b0; op_rdy = 1'b0;
        mq.delete();
        m_hp = COLD; m_fa = COLD; m_ra = COLD; m_infl = 1'b0; just_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;
        // cold fetch into a stalled decoder
        repeat (8) cyc(0, 0, '0, 1, 1, 0);
        @(negedge clk);
        chk("cold_full", 32'(cnt), 32'd4);
        chk("cold_head", 32'(op_p), 32'(COLD));
        // streaming
        repeat (20) cyc(0, 0, '0, 1, 1, 1);
        // flush mid-stream
        cyc(0, 0, '0, 1, 1, 0);
        cyc(0, 1, 17'h1234, 1, 1, 0);
        repeat (10) cyc(0, 0, '0, 1, 1, 1);
        // bus contention 1,0,0,1
        for (int i = 0; i < 16; i++) cyc(0, 0, '0, 1, (i % 4 == 0) || (i % 4 == 3), 1);
        // address wrap
        cyc(0, 1, 17'h1FFFE, 1, 1, 0);
        repeat (8) cyc(0, 0, '0, 1, 1, 0);
        // reset while a return is in flight
        cyc(0, 0, '0, 1, 1, 1);
        cyc(0, 0, '0, 1, 1, 0);
        cyc(1, 0, '0, 1, 1, 0);
        repeat (4) cyc(0, 0, '0, 1, 1, 1);
        // flush with fetch disabled
        cyc(0, 1, 17'h0ABCD, 0, 1, 1);
        repeat (3) cyc(0, 0, '0, 0, 1, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0,
                ($urandom_range(0, 3) == 0) ? 17'h1FFFE : ASZ'($urandom),
                $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
